// File: rtl/merge_sort_ctrl.sv
// merge_sort_ctrl: loads a block of N = 2^LOG_N keys into a ping-pong buffer,
// runs LOG_N bottom-up stable merge passes (one element per cycle) and drains
// the ascending result over a valid/ready stream.
module merge_sort_ctrl #(
  parameter int DATA_W = 8,
  parameter int LOG_N  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int N  = 1 << LOG_N;
  localparam int CW = LOG_N + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MERGE = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] load_cnt_q, load_cnt_d;
  logic [CW-1:0] k_q, k_d;          // destination index within a pass
  logic [CW-1:0] i_q, i_d;          // left-run read pointer (absolute)
  logic [CW-1:0] j_q, j_d;          // right-run read pointer (absolute)
  logic [CW-1:0] base_q, base_d;    // start of the current run pair
  logic [CW-1:0] w_q, w_d;          // run width of the current pass
  logic [CW-1:0] out_cnt_q, out_cnt_d;  // elements fetched into out_data
  logic          src_sel_q, src_sel_d;  // 0: src=buf_a, 1: src=buf_b

  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] buf_a_q [N];
  logic [DATA_W-1:0] buf_b_q [N];

  logic              wr_a_en_s, wr_b_en_s;
  logic [LOG_N-1:0]  wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  logic              load_fire_s, out_fire_s;
  logic [CW-1:0]     left_end_s, right_end_s;
  logic              left_ok_s, right_ok_s, take_left_s;
  logic              pass_end_s, last_pass_s;
  logic [DATA_W-1:0] src_i_s, src_j_s, res_s;

  assign load_fire_s = in_valid && in_ready_q;
  assign out_fire_s  = out_valid_q && out_ready;
  assign left_end_s  = base_q + w_q;
  assign right_end_s = left_end_s + w_q;
  assign left_ok_s   = (i_q < left_end_s);
  assign right_ok_s  = (j_q < right_end_s);
  assign src_i_s     = src_sel_q ? buf_b_q[i_q[LOG_N-1:0]] : buf_a_q[i_q[LOG_N-1:0]];
  assign src_j_s     = src_sel_q ? buf_b_q[j_q[LOG_N-1:0]] : buf_a_q[j_q[LOG_N-1:0]];
  // Stable merge: on ties the left run wins.
  assign take_left_s = left_ok_s && (!right_ok_s || (src_i_s <= src_j_s));
  assign pass_end_s  = (k_q == CW'(N - 1));
  assign last_pass_s = (w_q == CW'(N / 2));
  // After the final pass swap, src_sel points at the buffer holding the result.
  assign res_s       = src_sel_q ? buf_b_q[out_cnt_q[LOG_N-1:0]] : buf_a_q[out_cnt_q[LOG_N-1:0]];

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // State, counters and registered outputs with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      base_q      <= '0;
      w_q         <= '0;
      out_cnt_q   <= '0;
      src_sel_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      base_q      <= base_d;
      w_q         <= w_d;
      out_cnt_q   <= out_cnt_d;
      src_sel_q   <= src_sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Ping-pong key storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_a_en_s) buf_a_q[wr_addr_s] <= wr_data_s;
    if (wr_b_en_s) buf_b_q[wr_addr_s] <= wr_data_s;
  end

  // Next-state: idle -> load -> merge passes -> drain -> idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD; else state_d = S_IDLE;
      S_LOAD:  if (load_fire_s && (load_cnt_q == CW'(N - 1))) state_d = S_MERGE;
               else state_d = S_LOAD;
      S_MERGE: if (pass_end_s && last_pass_s) state_d = S_OUT; else state_d = S_MERGE;
      S_OUT:   if (out_fire_s && (out_cnt_q == CW'(N))) state_d = S_IDLE; else state_d = S_OUT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, buffer writes and next values of the registered outputs.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    k_d         = k_q;
    i_d         = i_q;
    j_d         = j_q;
    base_d      = base_q;
    w_d         = w_q;
    out_cnt_d   = out_cnt_q;
    src_sel_d   = src_sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    wr_a_en_s   = 1'b0;
    wr_b_en_s   = 1'b0;
    wr_addr_s   = '0;
    wr_data_s   = '0;
    in_ready_d  = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        load_cnt_d = '0;
      end
      S_LOAD: begin
        if (load_fire_s) begin
          wr_a_en_s  = 1'b1;
          wr_addr_s  = load_cnt_q[LOG_N-1:0];
          wr_data_s  = in_data;
          load_cnt_d = load_cnt_q + CW'(1);
          k_d        = '0;
          i_d        = '0;
          j_d        = CW'(1);
          base_d     = '0;
          w_d        = CW'(1);
          src_sel_d  = 1'b0;
        end else begin
          load_cnt_d = load_cnt_q;
        end
      end
      S_MERGE: begin
        wr_a_en_s = src_sel_q;
        wr_b_en_s = !src_sel_q;
        wr_addr_s = k_q[LOG_N-1:0];
        wr_data_s = take_left_s ? src_i_s : src_j_s;
        if (pass_end_s) begin
          k_d         = '0;
          base_d      = '0;
          i_d         = '0;
          j_d         = w_q << 1;
          w_d         = w_q << 1;
          src_sel_d   = !src_sel_q;
          out_cnt_d   = '0;
          out_valid_d = 1'b0;
        end else if ((k_q + CW'(1)) == right_end_s) begin
          // Next run pair starts on the very next cycle (no bubble).
          k_d    = k_q + CW'(1);
          base_d = right_end_s;
          i_d    = right_end_s;
          j_d    = right_end_s + w_q;
        end else begin
          k_d = k_q + CW'(1);
          if (take_left_s) i_d = i_q + CW'(1);
          else             j_d = j_q + CW'(1);
        end
      end
      S_OUT: begin
        if (!out_valid_q || out_fire_s) begin
          if (out_cnt_q != CW'(N)) begin
            out_data_d  = res_s;
            out_valid_d = 1'b1;
            out_cnt_d   = out_cnt_q + CW'(1);
          end else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        load_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_merge_sort_ctrl.sv
// Scoreboard bench for merge_sort_ctrl: LOG_N=2 and LOG_N=3 instances share
// the input stream; sel picks which one is started and observed.
module tb_merge_sort_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, in_valid, out_ready;
  logic [7:0] in_data;
  bit         sel;
  logic       start2, start3;
  assign start2 = start & ~sel;
  assign start3 = start & sel;

  logic       ir2, ov2, busy2, done2, ir3, ov3, busy3, done3;
  logic [7:0] od2, od3;

  merge_sort_ctrl #(.DATA_W(8), .LOG_N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
    .busy(busy2), .done(done2));

  merge_sort_ctrl #(.DATA_W(8), .LOG_N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(out_ready),
    .busy(busy3), .done(done3));

  logic       m_in_ready, m_out_valid, m_busy, m_done;
  logic [7:0] m_out_data;
  assign m_in_ready  = sel ? ir3 : ir2;
  assign m_out_valid = sel ? ov3 : ov2;
  assign m_out_data  = sel ? od3 : od2;
  assign m_busy      = sel ? busy3 : busy2;
  assign m_done      = sel ? done3 : done2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_lat = 0;
  int load_cyc = 0;
  int n_out = 0;
  int done_cnt = 0;
  int done_base = 0;
  int busy_drop = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stim[$];
  logic [7:0] expv[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake.
  initial begin
    bit active;
    bit seen;
    active = 1'b0;
    seen   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        seen   = 1'b0;
      end else begin
        if (m_out_valid && !seen) begin
          seen = 1'b1;
          check("first_valid_latency", cyc - load_cyc, exp_lat);
        end
        if (m_out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_output: got 0x%0h expected no output", m_out_data);
          end else begin
            check("out_data", m_out_data, exp_q.pop_front());
          end
        end else if (m_out_valid && exp_q.size() > 0) begin
          check("stall_hold", m_out_data, exp_q[0]);
        end
        if (m_done) done_cnt++;
        if (m_busy) active = 1'b1;
        else if (active) begin
          active = 1'b0;
          if (!m_done) busy_drop++;
        end
        if (!m_busy) seen = 1'b0;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"},  m_in_ready,  0);
    check({tag, "_out_valid"}, m_out_valid, 0);
    check({tag, "_out_data"},  m_out_data,  0);
    check({tag, "_busy"},      m_busy,      0);
    check({tag, "_done"},      m_done,      0);
  endtask

  task automatic load_block(input bit s, input bit gap, input bit noise);
    sel       = s;
    exp_lat   = s ? 25 : 9;
    done_base = done_cnt;
    foreach (expv[k]) exp_q.push_back(expv[k]);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < stim.size(); k++) begin
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = stim[k];
      if (noise && (k == 1)) start = 1'b1;
      @(negedge clk);
      while (!m_in_ready && (t < 50)) begin
        @(negedge clk);
        t++;
      end
      if (!m_in_ready) begin
        check("load_timeout", 0, 1);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      @(posedge clk); #1;
      load_cyc = cyc;
      in_valid = 1'b0;
      start    = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_block();
    int t;
    t = 0;
    while ((done_cnt == done_base) && (t < 500)) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - done_base, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_held", busy_drop, 0);
  endtask

  task automatic wait_outs(input int cnt);
    int t;
    t = 0;
    while ((n_out < cnt) && (t < 200)) begin
      @(posedge clk);
      t++;
    end
    if (n_out < cnt) check("drain_timeout", n_out, cnt);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // "badc" -> "abcd"
    stim = '{8'h62, 8'h61, 8'h64, 8'h63};
    expv = '{8'h61, 8'h62, 8'h63, 8'h64};
    load_block(1'b0, 1'b0, 1'b0);
    wait_block();

    // duplicates, stable ordering
    stim = '{8'h05, 8'h05, 8'h01, 8'h05};
    expv = '{8'h01, 8'h05, 8'h05, 8'h05};
    load_block(1'b0, 1'b0, 1'b0);
    wait_block();

    // unsigned compare at extremes
    stim = '{8'hFF, 8'h00, 8'h80, 8'h7F};
    expv = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    load_block(1'b0, 1'b0, 1'b0);
    wait_block();

    // LOG_N=3 reverse order, 24 merge cycles
    stim = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    expv = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    load_block(1'b1, 1'b0, 1'b0);
    wait_block();

    // gapped input plus a 3-cycle output stall mid-drain
    stim = '{8'h30, 8'h10, 8'h40, 8'h20};
    expv = '{8'h10, 8'h20, 8'h30, 8'h40};
    nb = n_out;
    load_block(1'b0, 1'b1, 1'b0);
    wait_outs(nb + 2);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_block();

    // start pulses in LOAD, MERGE and OUT are ignored
    stim = '{8'h03, 8'h01, 8'h02, 8'h00};
    expv = '{8'h00, 8'h01, 8'h02, 8'h03};
    nb = n_out;
    load_block(1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_outs(nb + 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_block();

    // reset mid-MERGE, then a clean block
    stim = '{8'h09, 8'h08, 8'h07, 8'h06};
    expv = '{8'h06, 8'h07, 8'h08, 8'h09};
    load_block(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    stim = '{8'h64, 8'h63, 8'h62, 8'h61};
    expv = '{8'h61, 8'h62, 8'h63, 8'h64};
    load_block(1'b0, 1'b0, 1'b0);
    wait_block();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
